// File: rtl/imem_icache_if.sv
// imem_icache_if -- bus bundle between the fetch stage / backing memory and
// the instruction cache.
//   fetch side : imem_addr_i (byte address), imem_data_o, imem_stall_o, flush_i
//   memory side: mem_req_v_o, mem_addr_o (word aligned), mem_ready_i, mem_data_i
// Signal names keep the cache's point of view (_i = into cache, _o = out of it).
// Modports:
//   slave  : the cache
//   master : fetch stage plus backing memory (or a testbench standing in for them)
interface imem_icache_if;
  logic [31:0] imem_addr_i;
  logic [31:0] imem_data_o;
  logic        imem_stall_o;
  logic        flush_i;
  logic        mem_req_v_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;

  modport slave (
    input  imem_addr_i, flush_i, mem_ready_i, mem_data_i,
    output imem_data_o, imem_stall_o, mem_req_v_o, mem_addr_o
  );

  modport master (
    output imem_addr_i, flush_i, mem_ready_i, mem_data_i,
    input  imem_data_o, imem_stall_o, mem_req_v_o, mem_addr_o
  );
endinterface

// File: rtl/imem_icache.sv
// imem_icache -- direct-mapped instruction cache with in-order line refill.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : synchronous active-high reset
//   bus    : imem_icache_if.slave (fetch request/response, refill read port)
// Parameters:
//   SETS       : number of lines (power of 2, >= 2)
//   LINE_WORDS : 32-bit words per line (power of 2, >= 2)
//
// state  | meaning
// IDLE   | lookup; a hit returns data in the same cycle, a miss starts a refill
// REFILL | reading the latched line from memory, word 0 upward, one per ready
module imem_icache #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  imem_icache_if.slave   bus
);
  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS  = $clog2(SETS);
  localparam int TAG_BITS  = 32 - 2 - WORD_BITS - IDX_BITS;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                state_q, state_d;
  logic [WORD_BITS-1:0]  cnt_q;
  logic [TAG_BITS-1:0]   base_tag_q;
  logic [IDX_BITS-1:0]   base_idx_q;
  logic                  flushed_q;
  logic [SETS-1:0]       valid_q;
  logic [TAG_BITS-1:0]   tag_q  [SETS];
  logic [31:0]           data_q [SETS][LINE_WORDS];

  logic [TAG_BITS-1:0]   req_tag;
  logic [IDX_BITS-1:0]   req_idx;
  logic [WORD_BITS-1:0]  req_word;
  logic                  unused_offset;

  logic hit, miss, line_write, refill_done;

  assign req_tag       = bus.imem_addr_i[31 -: TAG_BITS];
  assign req_idx       = bus.imem_addr_i[2 + WORD_BITS +: IDX_BITS];
  assign req_word      = bus.imem_addr_i[2 +: WORD_BITS];
  assign unused_offset = ^bus.imem_addr_i[1:0];

  // Outputs are forced to their idle values while rst_i is high so that a
  // reset landing mid-refill drops the memory request in the same cycle.
  always_comb begin
    state_d          = state_q;
    hit              = 1'b0;
    miss             = 1'b0;
    line_write       = 1'b0;
    refill_done      = 1'b0;
    bus.imem_stall_o = 1'b1;
    bus.imem_data_o  = NOP;
    bus.mem_req_v_o  = 1'b0;
    bus.mem_addr_o   = 32'h0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
            hit              = 1'b1;
            bus.imem_stall_o = 1'b0;
            bus.imem_data_o  = data_q[req_idx][req_word];
          end else begin
            miss    = 1'b1;
            state_d = REFILL;
          end
        end
        REFILL: begin
          bus.mem_req_v_o = 1'b1;
          bus.mem_addr_o  = {base_tag_q, base_idx_q, cnt_q, 2'b00};
          if (bus.mem_ready_i) begin
            line_write = 1'b1;
            if (cnt_q == WORD_BITS'(LINE_WORDS - 1)) begin
              refill_done = 1'b1;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_tag_q <= '0;
      base_idx_q <= '0;
      flushed_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q <= state_d;
      if (miss) begin
        base_tag_q <= req_tag;
        base_idx_q <= req_idx;
        cnt_q      <= '0;
        flushed_q  <= 1'b0;
      end
      // cnt_q wraps back to zero on the last word, ready for the next miss
      if (line_write) cnt_q <= cnt_q + WORD_BITS'(1);
      // Remember a flush seen anywhere in the refill; the line fetched
      // around it may be stale, so it must not become valid.
      if (state_q == REFILL && bus.flush_i) flushed_q <= 1'b1;
      if (bus.flush_i) valid_q <= '0;
      else if (refill_done && !flushed_q) valid_q[base_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_write) data_q[base_idx_q][cnt_q] <= bus.mem_data_i;
    if (refill_done) tag_q[base_idx_q] <= base_tag_q;
  end

endmodule

// File: tb/tb_imem_icache.sv
module tb_imem_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;
  logic [31:0] exp_addr_q[$];

  imem_icache_if bus ();

  imem_icache #(.SETS(16), .LINE_WORDS(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing memory contents: line 0x100 holds 0xA0+word, elsewhere a pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h000_0010) return 32'h0000_00A0 + 32'(a[3:2]);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic int refill_len(input logic [15:0] pat);
    int ones = 0;
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      if (ones < 4) begin
        n++;
        if (pat[i]) ones++;
      end
    end
    return n;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step_end();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_check(input logic [31:0] addr, input string tag);
    bus.imem_addr_i = addr;
    @(negedge clk);
    chk1({tag, "_stall"}, bus.imem_stall_o, 1'b0);
    chk32({tag, "_data"}, bus.imem_data_o, mem_word(addr));
    chk1({tag, "_req"}, bus.mem_req_v_o, 1'b0);
    step_end();
  endtask

  // Drive a miss at addr and serve the refill with the given ready pattern.
  // Expected refill addresses are queued up front and popped per accepted word.
  task automatic run_fill(input logic [31:0] addr, input logic [15:0] rdy_pat,
                          input int flush_at, input bit expect_valid);
    logic [31:0] base;
    int cyc;
    base = {addr[31:4], 4'h0};
    bus.imem_addr_i = addr;
    bus.flush_i     = 1'b0;
    bus.mem_ready_i = 1'b0;
    for (int w = 0; w < 4; w++) exp_addr_q.push_back(base + 32'(w * 4));
    @(negedge clk);
    chk1("miss_stall", bus.imem_stall_o, 1'b1);
    chk32("miss_nop", bus.imem_data_o, 32'h0000_0013);
    chk1("miss_req", bus.mem_req_v_o, 1'b0);
    step_end();
    cyc = 0;
    while (exp_addr_q.size() != 0 && cyc < 32) begin
      bus.mem_ready_i = (cyc < 16) ? rdy_pat[cyc[3:0]] : 1'b1;
      bus.mem_data_i  = mem_word(exp_addr_q[0]);
      bus.flush_i     = (cyc == flush_at);
      @(negedge clk);
      chk1("refill_req", bus.mem_req_v_o, 1'b1);
      chk32("refill_addr", bus.mem_addr_o, exp_addr_q[0]);
      chk1("refill_stall", bus.imem_stall_o, 1'b1);
      if (bus.mem_ready_i) void'(exp_addr_q.pop_front());
      step_end();
      cyc++;
    end
    chk32("refill_words_left", 32'(exp_addr_q.size()), 32'd0);
    chk32("refill_cycles", 32'(cyc), 32'(refill_len(rdy_pat)));
    exp_addr_q.delete();
    bus.mem_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    if (expect_valid) hit_check(addr, "post_fill");
  endtask

  initial begin
    bus.imem_addr_i = 32'h0000_0104;
    bus.flush_i     = 1'b0;
    bus.mem_ready_i = 1'b0;
    bus.mem_data_i  = 32'h0;

    // reset state
    @(negedge clk);
    chk1("rst_stall", bus.imem_stall_o, 1'b1);
    chk1("rst_req", bus.mem_req_v_o, 1'b0);
    chk32("rst_addr", bus.mem_addr_o, 32'h0);
    chk32("rst_nop", bus.imem_data_o, 32'h0000_0013);
    step_end();
    step_end();
    rst = 1'b0;

    // cold miss, ready every cycle; first hit returns 0xA1
    run_fill(32'h0000_0104, 16'hFFFF, -1, 1'b1);

    // hit streaming, mem_ready asserted but ignored in IDLE
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) hit_check(32'h0000_0100 + 32'(i * 4), "stream");
    bus.mem_ready_i = 1'b0;

    // backpressure 1,0,0,1,1,0,1 then check the line words in order
    run_fill(32'h0000_0200, 16'h0059, -1, 1'b1);
    for (int i = 0; i < 4; i++) hit_check(32'h0000_0200 + 32'(i * 4), "bp_line");

    // conflict on index 0
    run_fill(32'h0000_0100, 16'hFFFF, -1, 1'b1);
    run_fill(32'h0000_0500, 16'hFFFF, -1, 1'b1);
    run_fill(32'h0000_0100, 16'hFFFF, -1, 1'b1);

    // second index, then flush in IDLE: hit still served in the flush cycle
    run_fill(32'h0000_0140, 16'hFFFF, -1, 1'b1);
    hit_check(32'h0000_0148, "pre_flush");
    bus.flush_i = 1'b1;
    hit_check(32'h0000_0144, "flush_cycle_hit");
    bus.flush_i = 1'b0;
    run_fill(32'h0000_0140, 16'hFFFF, -1, 1'b1);

    // flush on the 2nd refill cycle: line stays invalid, everything misses
    run_fill(32'h0000_0300, 16'hFFFF, 1, 1'b0);
    run_fill(32'h0000_0300, 16'hFFFF, -1, 1'b1);
    run_fill(32'h0000_0140, 16'hFFFF, -1, 1'b1);
    run_fill(32'h0000_0100, 16'hFFFF, -1, 1'b1);

    // flush on the final refill cycle also keeps the line invalid
    run_fill(32'h0000_0180, 16'hFFFF, 3, 1'b0);
    bus.imem_addr_i = 32'h0000_0180;
    @(negedge clk);
    chk1("flush_last_remiss", bus.imem_stall_o, 1'b1);
    step_end();
    // DUT is now in REFILL for 0x180; reset it when cnt reaches 2
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = mem_word(32'h0000_0180);
    @(negedge clk);
    chk32("rstmid_addr0", bus.mem_addr_o, 32'h0000_0180);
    step_end();
    bus.mem_data_i  = mem_word(32'h0000_0184);
    @(negedge clk);
    chk32("rstmid_addr1", bus.mem_addr_o, 32'h0000_0184);
    step_end();
    bus.mem_data_i  = mem_word(32'h0000_0188);
    @(negedge clk);
    chk32("rstmid_addr2", bus.mem_addr_o, 32'h0000_0188);
    rst = 1'b1;
    #1;
    chk1("rstmid_req_during", bus.mem_req_v_o, 1'b0);
    chk32("rstmid_addr_during", bus.mem_addr_o, 32'h0);
    step_end();
    rst = 1'b0;
    bus.mem_ready_i = 1'b0;
    // re-miss and refill from word 0
    run_fill(32'h0000_0180, 16'hFFFF, -1, 1'b1);
    hit_check(32'h0000_018C, "rstmid_word3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/imem_icache.md
IMEM_ICACHE -- requirements
Module: imem_icache

Interface
REQ-001 Parameter SETS, default 16, number of direct-mapped lines (power of 2, >=2).
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 imem_addr_i  input  32 (rvga_word)  fetch byte address from the fetch stage.
REQ-006 imem_data_o  output  32 (rvga_word)  instruction word for imem_addr_i.
REQ-007 imem_stall_o  output  1  imem_data_o not valid this cycle; fetch holds PC/IR.
REQ-008 flush_i  input  1  invalidate all lines (fence.i).
REQ-009 mem_req_v_o  output  1  backing-memory read request valid.
REQ-010 mem_addr_o  output  32  word-aligned backing-memory read address.
REQ-011 mem_ready_i  input  1  backing memory returns mem_data_i this cycle.
REQ-012 mem_data_i  input  32  backing-memory read data.

Function
REQ-013 Address split: offset = imem_addr_i[1:0] (ignored), word = next log2(LINE_WORDS) bits, index = next log2(SETS) bits, tag = remaining upper bits.
REQ-014 Storage: per set one valid bit, one tag, LINE_WORDS data words.
REQ-015 Hit = state IDLE and valid[index] and tag match; on hit imem_data_o = data[index][word] combinationally, same cycle, imem_stall_o = 0.
REQ-016 imem_stall_o = 1 whenever not a hit, including every cycle in REFILL and the miss-detect cycle.
REQ-017 imem_data_o = 32'h0000_0013 (NOP) whenever imem_stall_o = 1.
REQ-018 FSM states: IDLE, REFILL.
REQ-019 IDLE -> REFILL on a miss; at that edge latch line base {tag,index} and clear word counter cnt to 0.
REQ-020 In REFILL: mem_req_v_o = 1, mem_addr_o = {latched tag, latched index, cnt, 2'b00}; mem_req_v_o = 0 and mem_addr_o = 0 in IDLE.
REQ-021 Each REFILL cycle with mem_ready_i = 1: write mem_data_i to data[latched index][cnt], cnt increments; no write when mem_ready_i = 0 (request held stable).
REQ-022 On mem_ready_i with cnt = LINE_WORDS-1: write tag, set valid, return to IDLE; hit available the following cycle (miss penalty = LINE_WORDS ready cycles + 1).
REQ-023 Refill uses only latched address; changes on imem_addr_i during REFILL have no effect on it.
REQ-024 Refill words fill in ascending order from word 0 (no critical-word-first).
REQ-025 flush_i in IDLE: all valid bits cleared at the edge; a hit in the flush cycle still returns data that cycle.
REQ-026 flush_i during REFILL: all valid bits cleared, refill runs to completion, the refilled line is marked valid only if no flush_i occurred at any cycle of that refill including the final one.
REQ-027 mem_ready_i in IDLE is ignored.

Reset
REQ-028 rst_i at an edge: state IDLE, cnt 0, all valid bits 0; tag/data arrays need not be reset.
REQ-029 During and after reset: mem_req_v_o 0, mem_addr_o 0, imem_stall_o follows REQ-016 (1 for any address, cold cache); rst_i mid-REFILL abandons refill, line stays invalid.

Verification
REQ-030 Cold miss: after reset imem_addr_i=0x0000_0104, memory ready every cycle returning 0xA0+word -> mem_addr_o 0x100,0x104,0x108,0x10C on 4 consecutive cycles, then imem_data_o=0xA1, stall 0.
REQ-031 Hit streaming: after REQ-030 fill, addresses 0x100..0x10C one per cycle -> data 0xA0..0xA3, stall 0 every cycle, mem_req_v_o 0.
REQ-032 Backpressure: miss to 0x200 with mem_ready_i pattern 1,0,0,1,1,0,1 -> mem_addr_o holds 0x204 over 3 cycles, holds 0x20C over 2, 4 words written in order, exit after 7th cycle.
REQ-033 Conflict: fill 0x100 then access 0x500 (same index 0, SETS=16) -> miss, refill, then 0x100 misses again.
REQ-034 Flush mid-refill: flush_i on 2nd REFILL cycle of 0x300 -> refill completes, next cycle at 0x300 is a miss, 0x100 also misses.
REQ-035 Reset mid-refill: rst_i during cnt=2 -> next cycle mem_req_v_o 0, state IDLE, address re-misses and refills from word 0.
